// File: rtl/svga_sync_if.sv
// svga_sync_if: raster timing bundle (sync strobes, visible-area enable, pixel coordinates)
// Ports (master drives / slave reads): hsync, vsync, video_enable, pixel_x[10:0], pixel_y[9:0]
interface svga_sync_if;
    logic        hsync;
    logic        vsync;
    logic        video_enable;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    modport master (output hsync, vsync, video_enable, pixel_x, pixel_y);
    modport slave  (input  hsync, vsync, video_enable, pixel_x, pixel_y);
endinterface

// File: rtl/svga_sync.sv
// svga_sync: 800x600@72Hz raster timing generator, one pixel per clock, all outputs registered
// Ports: clock (pixel clock), reset (synchronous, active-high),
//        vga master: hsync, vsync (active level SYNC_POL), video_enable, pixel_x[10:0], pixel_y[9:0]
module svga_sync #(
    parameter int H_VIS    = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_VIS    = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    svga_sync_if.master vga
);
    localparam logic [10:0] H_LAST = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_VEND = 11'(H_VIS);
    localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_VEND = 10'(V_VIS);
    localparam logic [9:0]  VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_VIS + V_FP + V_SYNC);
    // Power-up values describe pixel (0,0) so the raster runs correctly with reset tied low.
    logic [10:0] h  = '0;
    logic [9:0]  v  = '0;
    logic        hs = ~SYNC_POL;
    logic        vs = ~SYNC_POL;
    logic        ve = 1'b1;
    logic [10:0] h_nx;
    logic [9:0]  v_nx;
    always_comb begin
        h_nx = (h == H_LAST) ? '0 : h + 11'd1;
        v_nx = (h != H_LAST) ? v : (v == V_LAST) ? '0 : v + 10'd1;
    end
    // Decodes use the next counter values so they land on the same edge as the coordinates.
    always_ff @(posedge clock) begin
        if (reset) begin
            h  <= '0;
            v  <= '0;
            hs <= ~SYNC_POL;
            vs <= ~SYNC_POL;
            ve <= 1'b0;
        end else begin
            h  <= h_nx;
            v  <= v_nx;
            hs <= (h_nx >= HS_BEG && h_nx < HS_END) ? SYNC_POL : ~SYNC_POL;
            vs <= (v_nx >= VS_BEG && v_nx < VS_END) ? SYNC_POL : ~SYNC_POL;
            ve <= (h_nx < H_VEND) && (v_nx < V_VEND);
        end
    end
    assign vga.pixel_x      = h;
    assign vga.pixel_y      = v;
    assign vga.hsync        = hs;
    assign vga.vsync        = vs;
    assign vga.video_enable = ve;
endmodule

// File: tb/tb_svga_sync.sv
// tb_svga_sync: randomized self-checking bench for svga_sync (full mode plus a scaled-down mode)
module tb_svga_sync;
    localparam int FA = 1040 * 666;
    localparam int HTB = 23;
    localparam int FB = HTB * 19;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;
    svga_sync_if ifa ();
    svga_sync_if ifb ();
    svga_sync dut_a (.clock(clk), .reset(rst_a), .vga(ifa));
    svga_sync #(
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) dut_b (.clock(clk), .reset(rst_b), .vga(ifb));
    // Reference: a frame is just a clock count since reset; coordinates and decodes follow by arithmetic.
    int ta = 0;
    int tb_t = 0;
    bit ha = 1'b0;
    bit hb = 1'b0;
    always @(posedge clk) begin
        ta   <= rst_a ? 0 : (ta + 1) % FA;
        ha   <= rst_a;
        tb_t <= rst_b ? 0 : (tb_t + 1) % FB;
        hb   <= rst_b;
    end
    function automatic logic [23:0] model(int t, bit held, int hv, int hf, int hsw, int hbp,
                                          int vv, int vf, int vsw, bit pol);
        int ht, x, y;
        ht = hv + hf + hsw + hbp;
        x = t % ht;
        y = t / ht;
        if (held) return {21'd0, ~pol, ~pol, 1'b0};
        return {11'(x), 10'(y),
                (x >= hv + hf && x < hv + hf + hsw) ? pol : ~pol,
                (y >= vv + vf && y < vv + vf + vsw) ? pol : ~pol,
                1'(x < hv && y < vv)};
    endfunction
    logic [23:0] got_a, exp_a, got_b, exp_b;
    always_comb begin
        got_a = {ifa.pixel_x, ifa.pixel_y, ifa.hsync, ifa.vsync, ifa.video_enable};
        got_b = {ifb.pixel_x, ifb.pixel_y, ifb.hsync, ifb.vsync, ifb.video_enable};
        exp_a = model(ta, ha, 800, 56, 120, 64, 600, 37, 6, 1'b1);
        exp_b = model(tb_t, hb, 16, 2, 3, 2, 12, 2, 2, 1'b0);
    end
    int total = 0;
    int bad = 0;

    task automatic test_powerup();
        #1;
        total++;
        if (got_a !== 24'h000001) begin
            bad++;
            $display("FAIL powerup_state_a: got %h want %h", got_a, 24'h000001);
        end
        total++;
        if (got_b !== 24'h000007) begin
            bad++;
            $display("FAIL powerup_state_b: got %h want %h", got_b, 24'h000007);
        end
        for (int i = 0; i < 2 * 1040 + 5; i++) begin
            @(negedge clk);
            total += 2;
            if (got_a !== exp_a) begin
                bad++;
                $display("FAIL powerup_run_a t=%0d: got %h want %h", ta, got_a, exp_a);
            end
            if (got_b !== exp_b) begin
                bad++;
                $display("FAIL powerup_run_b t=%0d: got %h want %h", tb_t, got_b, exp_b);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total += 2;
            if (got_a !== 24'h000000) begin
                bad++;
                $display("FAIL reset_hold_a: got %h want %h", got_a, 24'h000000);
            end
            if (got_b !== 24'h000006) begin
                bad++;
                $display("FAIL reset_hold_b: got %h want %h", got_b, 24'h000006);
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        total += 2;
        if (got_a !== {11'd1, 10'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_release_a: got %h want %h", got_a, {11'd1, 10'd0, 1'b0, 1'b0, 1'b1});
        end
        if (got_b !== exp_b) begin
            bad++;
            $display("FAIL reset_release_b: got %h want %h", got_b, exp_b);
        end
    endtask

    task automatic test_line();
        int hs_hi = 0, rise_x = -1, fall_x = -1;
        logic prev_hs;
        logic [10:0] px;
        logic [9:0] py;
        prev_hs = ifa.hsync;
        px = ifa.pixel_x;
        py = ifa.pixel_y;
        for (int i = 0; i < 2 * 1040; i++) begin
            @(negedge clk);
            total++;
            if (got_a !== exp_a) begin
                bad++;
                $display("FAIL line_run t=%0d: got %h want %h", ta, got_a, exp_a);
            end
            if (ifa.pixel_y == 10'd0 && ifa.hsync) hs_hi++;
            if (ifa.pixel_y == 10'd0 && ifa.hsync && !prev_hs) rise_x = int'(ifa.pixel_x);
            if (ifa.pixel_y == 10'd0 && !ifa.hsync && prev_hs) fall_x = int'(ifa.pixel_x);
            if (ifa.pixel_y == 10'd0 && (ifa.pixel_x == 11'd799 || ifa.pixel_x == 11'd800)) begin
                total++;
                if (ifa.video_enable !== (ifa.pixel_x == 11'd799)) begin
                    bad++;
                    $display("FAIL line_ve_edge x=%0d: got %b want %b", ifa.pixel_x, ifa.video_enable, ifa.pixel_x == 11'd799);
                end
            end
            if (px == 11'd1039) begin
                total++;
                if (ifa.pixel_x !== 11'd0 || ifa.pixel_y !== py + 10'd1) begin
                    bad++;
                    $display("FAIL line_wrap: got x=%0d y=%0d want x=0 y=%0d", ifa.pixel_x, ifa.pixel_y, py + 10'd1);
                end
            end
            prev_hs = ifa.hsync;
            px = ifa.pixel_x;
            py = ifa.pixel_y;
        end
        total += 3;
        if (hs_hi !== 120) begin
            bad++;
            $display("FAIL line_hs_width: got %0d want 120", hs_hi);
        end
        if (rise_x !== 856) begin
            bad++;
            $display("FAIL line_hs_rise: got %0d want 856", rise_x);
        end
        if (fall_x !== 976) begin
            bad++;
            $display("FAIL line_hs_fall: got %0d want 976", fall_x);
        end
    endtask

    task automatic test_frame();
        int vs_act = 0, ve_late = 0;
        logic [10:0] px;
        logic [9:0] py;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        px = ifb.pixel_x;
        py = ifb.pixel_y;
        for (int i = 0; i < 2 * FB; i++) begin
            @(negedge clk);
            total++;
            if (got_b !== exp_b) begin
                bad++;
                $display("FAIL frame_run t=%0d: got %h want %h", tb_t, got_b, exp_b);
            end
            if (ifb.vsync == 1'b0) vs_act++;
            if (ifb.video_enable && ifb.pixel_y >= 10'd12) ve_late++;
            if (px == 11'd22 && py == 10'd18) begin
                total++;
                if (ifb.pixel_x !== 11'd0 || ifb.pixel_y !== 10'd0) begin
                    bad++;
                    $display("FAIL frame_wrap: got x=%0d y=%0d want x=0 y=0", ifb.pixel_x, ifb.pixel_y);
                end
            end
            px = ifb.pixel_x;
            py = ifb.pixel_y;
        end
        total += 2;
        if (vs_act !== 2 * 2 * HTB) begin
            bad++;
            $display("FAIL frame_vs_width: got %0d want %0d", vs_act, 2 * 2 * HTB);
        end
        if (ve_late !== 0) begin
            bad++;
            $display("FAIL frame_ve_blank: got %0d want 0", ve_late);
        end
    endtask

    task automatic test_periods();
        int ra[$];
        int rb[$];
        logic pa, pb;
        pa = ifa.hsync;
        pb = ifb.vsync;
        for (int i = 0; i < 3300 && (ra.size() < 3 || rb.size() < 3); i++) begin
            @(negedge clk);
            total += 2;
            if (got_a !== exp_a) begin
                bad++;
                $display("FAIL period_run_a t=%0d: got %h want %h", ta, got_a, exp_a);
            end
            if (got_b !== exp_b) begin
                bad++;
                $display("FAIL period_run_b t=%0d: got %h want %h", tb_t, got_b, exp_b);
            end
            if (ifa.hsync && !pa) ra.push_back(i);
            if (!ifb.vsync && pb) rb.push_back(i);
            pa = ifa.hsync;
            pb = ifb.vsync;
        end
        total += 2;
        if (ra.size() < 3) begin
            bad++;
            $display("FAIL period_hs_timeout: got %0d edges want 3", ra.size());
        end else if (ra[1] - ra[0] !== 1040 || ra[2] - ra[1] !== 1040) begin
            bad++;
            $display("FAIL period_hs: got %0d,%0d want 1040", ra[1] - ra[0], ra[2] - ra[1]);
        end
        if (rb.size() < 3) begin
            bad++;
            $display("FAIL period_vs_timeout: got %0d edges want 3", rb.size());
        end else if (rb[1] - rb[0] !== FB || rb[2] - rb[1] !== FB) begin
            bad++;
            $display("FAIL period_vs: got %0d,%0d want %0d", rb[1] - rb[0], rb[2] - rb[1], FB);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        int tx, ty;
        n = 0;
        while (ifa.pixel_x != 11'd500 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ifa.pixel_x !== 11'd500) begin
            bad++;
            $display("FAIL mid_reset_a_timeout: got x=%0d want 500", ifa.pixel_x);
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        total++;
        if (got_a !== 24'h000000) begin
            bad++;
            $display("FAIL mid_reset_a_hold: got %h want %h", got_a, 24'h000000);
        end
        @(negedge clk);
        total++;
        if (got_a !== {11'd1, 10'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset_a_resume: got %h want %h", got_a, {11'd1, 10'd0, 1'b0, 1'b0, 1'b1});
        end
        tx = int'($urandom_range(1, 22));
        ty = int'($urandom_range(1, 18));
        n = 0;
        while ((int'(ifb.pixel_x) != tx || int'(ifb.pixel_y) != ty) && n < FB + 5) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (int'(ifb.pixel_x) != tx || int'(ifb.pixel_y) != ty) begin
            bad++;
            $display("FAIL mid_reset_b_timeout: got x=%0d y=%0d want x=%0d y=%0d", ifb.pixel_x, ifb.pixel_y, tx, ty);
        end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        total++;
        if (got_b !== 24'h000006) begin
            bad++;
            $display("FAIL mid_reset_b_hold: got %h want %h", got_b, 24'h000006);
        end
        @(negedge clk);
        total++;
        if (got_b !== exp_b) begin
            bad++;
            $display("FAIL mid_reset_b_resume: got %h want %h", got_b, exp_b);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            int n;
            n = int'($urandom_range(50, 1200));
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                total += 2;
                if (got_a !== exp_a) begin
                    bad++;
                    $display("FAIL random_a t=%0d: got %h want %h", ta, got_a, exp_a);
                end
                if (got_b !== exp_b) begin
                    bad++;
                    $display("FAIL random_b t=%0d: got %h want %h", tb_t, got_b, exp_b);
                end
                rst_a = ($urandom_range(0, 599) == 0);
                rst_b = ($urandom_range(0, 149) == 0);
            end
        end
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    initial begin
        test_powerup();
        test_reset();
        test_line();
        test_frame();
        test_periods();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
